// File: rtl/control_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// control_sequencer_pkg
//   Shared encodings for the control sequencer and its instruction decoder:
//   4-bit FSM state codes, opcodes, register codes, ALU operation codes and
//   the decoded instruction class.
//
//   Build option: ILLEGAL_TRAP_EN -- when defined, the TRAP state exists and
//   illegal opcodes stop the core. When undefined, TRAP is not compiled in.
// ----------------------------------------------------------------------------
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_FETCH1 = 4'd0,
        ST_FETCH2 = 4'd1,
        ST_DECODE = 4'd2,
        ST_EX1    = 4'd3,
        ST_EX2    = 4'd4,
        ST_EX3    = 4'd5,
        ST_LDI1   = 4'd6,
        ST_LDI2   = 4'd7,
`ifdef ILLEGAL_TRAP_EN
        ST_HALT   = 4'd8,
        ST_TRAP   = 4'd9
`else
        ST_HALT   = 4'd8
`endif
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_MOV = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MOV,
        CLS_LDI,
        CLS_HLT,
        CLS_ILLEGAL
    } instr_class_e;

    // Register code to one-hot select/load vector (bit n = Rn).
    function automatic logic [3:0] reg_onehot(input logic [1:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        case (code)
            R0:      oh = 4'b0001;
            R1:      oh = 4'b0010;
            R2:      oh = 4'b0100;
            R3:      oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ----------------------------------------------------------------------------
// control_sequencer_if
//   Control bundle between the sequencer and the datapath/memory.
//   master : sequencer side (drives strobes, receives ready and ir)
//   slave  : datapath side (drives ready and ir, receives strobes)
//   Signals: ready, ir[7:0], mem_rd, sel_mem, sel_pc, sel_alu, sel_r[3:0],
//            load_ar, load_ir, load_op1, load_op2, load_flag, inc_pc,
//            load_r[3:0], alu_op[1:0], halted, error
// ----------------------------------------------------------------------------
interface control_sequencer_if;
    logic       ready;
    logic [7:0] ir;
    logic       mem_rd;
    logic       sel_mem;
    logic       sel_pc;
    logic       sel_alu;
    logic [3:0] sel_r;
    logic       load_ar;
    logic       load_ir;
    logic       load_op1;
    logic       load_op2;
    logic       load_flag;
    logic       inc_pc;
    logic [3:0] load_r;
    logic [1:0] alu_op;
    logic       halted;
    logic       error;

    modport master (
        input  ready, ir,
        output mem_rd, sel_mem, sel_pc, sel_alu, sel_r,
               load_ar, load_ir, load_op1, load_op2, load_flag, inc_pc,
               load_r, alu_op, halted, error
    );

    modport slave (
        output ready, ir,
        input  mem_rd, sel_mem, sel_pc, sel_alu, sel_r,
               load_ar, load_ir, load_op1, load_op2, load_flag, inc_pc,
               load_r, alu_op, halted, error
    );
endinterface

// File: rtl/control_sequencer_instr_decode.sv
// ----------------------------------------------------------------------------
// control_sequencer_instr_decode
//   Purely combinational decode of the instruction register.
//   i_ir[7:0]      : [7:4] opcode, [3:2] src, [1:0] dest
//   o_class        : instruction class (nop/alu/mov/ldi/hlt/illegal)
//   o_alu_op[1:0]  : ALU operation for ALU-class opcodes, ADD otherwise
//   o_src_oh[3:0]  : one-hot source register
//   o_dest_oh[3:0] : one-hot destination register
// ----------------------------------------------------------------------------
module control_sequencer_instr_decode
    import control_sequencer_pkg::*;
(
    input  logic [7:0]   i_ir,
    output instr_class_e o_class,
    output logic [1:0]   o_alu_op,
    output logic [3:0]   o_src_oh,
    output logic [3:0]   o_dest_oh
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        o_class  = CLS_ILLEGAL;
        o_alu_op = ALU_ADD;
        case (i_ir[7:4])
            OP_NOP: o_class = CLS_NOP;
            OP_ADD: begin o_class = CLS_ALU; o_alu_op = ALU_ADD; end
            OP_SUB: begin o_class = CLS_ALU; o_alu_op = ALU_SUB; end
            OP_AND: begin o_class = CLS_ALU; o_alu_op = ALU_AND; end
            OP_MOV: o_class = CLS_MOV;
            OP_LDI: o_class = CLS_LDI;
            OP_HLT: o_class = CLS_HLT;
            default: o_class = CLS_ILLEGAL;
        endcase
    end

    assign o_src_oh  = reg_onehot(i_ir[3:2]);
    assign o_dest_oh = reg_onehot(i_ir[1:0]);

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Central control FSM of the 8-bit CPU: sequences fetch, decode and
//   execute over the shared bus and handles the memory read handshake.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; forces FETCH1 and zeroes all outputs
//   bus   : control_sequencer_if.master (ready/ir in, all strobes out)
//
//   Build option: ILLEGAL_TRAP_EN -- illegal opcodes enter TRAP
//   (halted=1, error=1 until reset). Undefined: they execute as NOP and
//   error stays 0.
// ----------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);

    state_e       r_state;
    state_e       w_state_next;
    instr_class_e w_class;
    logic [1:0]   w_alu_op;
    logic [3:0]   w_src_oh;
    logic [3:0]   w_dest_oh;

    control_sequencer_instr_decode u_instr_decode (
        .i_ir      (bus.ir),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_src_oh  (w_src_oh),
        .o_dest_oh (w_dest_oh)
    );

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_FETCH1;
        else       r_state <= w_state_next;
    end

    // Next-state logic. ir is stable from DECODE until the next fetch, so
    // EX1 can still tell ALU from MOV by looking at the decoded class.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH1: w_state_next = ST_FETCH2;
            ST_FETCH2: if (bus.ready) w_state_next = ST_DECODE;
            ST_DECODE: begin
                case (w_class)
                    CLS_ALU, CLS_MOV: w_state_next = ST_EX1;
                    CLS_LDI:          w_state_next = ST_LDI1;
                    CLS_HLT:          w_state_next = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
                    CLS_ILLEGAL:      w_state_next = ST_TRAP;
`endif
                    default:          w_state_next = ST_FETCH1;
                endcase
            end
            ST_EX1:    w_state_next = (w_class == CLS_ALU) ? ST_EX2 : ST_FETCH1;
            ST_EX2:    w_state_next = ST_EX3;
            ST_EX3:    w_state_next = ST_FETCH1;
            ST_LDI1:   w_state_next = ST_LDI2;
            ST_LDI2:   if (bus.ready) w_state_next = ST_FETCH1;
            ST_HALT:   w_state_next = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:   w_state_next = ST_TRAP;
`endif
            default:   w_state_next = ST_FETCH1;
        endcase
    end

    // Strobes are Moore on the state (plus ir for register selects), and
    // Mealy on ready only in the two memory-wait states. Reset overrides
    // everything combinationally so a pending read is dropped at once.
    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.sel_mem   = 1'b0;
        bus.sel_pc    = 1'b0;
        bus.sel_alu   = 1'b0;
        bus.sel_r     = 4'b0000;
        bus.load_ar   = 1'b0;
        bus.load_ir   = 1'b0;
        bus.load_op1  = 1'b0;
        bus.load_op2  = 1'b0;
        bus.load_flag = 1'b0;
        bus.inc_pc    = 1'b0;
        bus.load_r    = 4'b0000;
        bus.alu_op    = ALU_ADD;
        bus.halted    = 1'b0;
        bus.error     = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH1, ST_LDI1: begin
                    bus.sel_pc  = 1'b1;
                    bus.load_ar = 1'b1;
                end
                ST_FETCH2: begin
                    bus.mem_rd = 1'b1;
                    if (bus.ready) begin
                        bus.sel_mem = 1'b1;
                        bus.load_ir = 1'b1;
                        bus.inc_pc  = 1'b1;
                    end
                end
                ST_EX1: begin
                    bus.sel_r = w_src_oh;
                    if (w_class == CLS_ALU) bus.load_op1 = 1'b1;
                    else                    bus.load_r   = w_dest_oh;
                end
                ST_EX2: begin
                    bus.sel_r    = w_dest_oh;
                    bus.load_op2 = 1'b1;
                end
                ST_EX3: begin
                    bus.sel_alu   = 1'b1;
                    bus.alu_op    = w_alu_op;
                    bus.load_flag = 1'b1;
                    bus.load_r    = w_dest_oh;
                end
                ST_LDI2: begin
                    bus.mem_rd = 1'b1;
                    if (bus.ready) begin
                        bus.sel_mem = 1'b1;
                        bus.load_r  = w_dest_oh;
                        bus.inc_pc  = 1'b1;
                    end
                end
                ST_HALT: bus.halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                // TRAP is only left through reset, so error stays set.
                ST_TRAP: begin
                    bus.halted = 1'b1;
                    bus.error  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
//   Self-checking bench for control_sequencer. The reference model expands
//   each instruction into the list of per-cycle output vectors the CPU's
//   microcycle rules call for, and every DUT cycle is compared against it.
//   Works with and without ILLEGAL_TRAP_EN.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    typedef struct packed {
        logic       mem_rd;
        logic       sel_mem;
        logic       sel_pc;
        logic       sel_alu;
        logic [3:0] sel_r;
        logic       load_ar;
        logic       load_ir;
        logic       load_op1;
        logic       load_op2;
        logic       load_flag;
        logic       inc_pc;
        logic [3:0] load_r;
        logic [1:0] alu_op;
        logic       halted;
        logic       error;
    } out_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cur_ir = 8'h00;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_inc = 0;
    int         n_cyc = 0;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.mem_rd    = bus_if.mem_rd;
        o.sel_mem   = bus_if.sel_mem;
        o.sel_pc    = bus_if.sel_pc;
        o.sel_alu   = bus_if.sel_alu;
        o.sel_r     = bus_if.sel_r;
        o.load_ar   = bus_if.load_ar;
        o.load_ir   = bus_if.load_ir;
        o.load_op1  = bus_if.load_op1;
        o.load_op2  = bus_if.load_op2;
        o.load_flag = bus_if.load_flag;
        o.inc_pc    = bus_if.inc_pc;
        o.load_r    = bus_if.load_r;
        o.alu_op    = bus_if.alu_op;
        o.halted    = bus_if.halted;
        o.error     = bus_if.error;
        return o;
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs after the falling edge, then compare
    // the settled outputs plus the bus/load invariants before the next rise.
    task automatic step(input string tag, input bit rdy, input out_t e);
        out_t o;
        @(negedge clk);
        reset        = 1'b0;
        bus_if.ready = rdy;
        bus_if.ir    = cur_ir;
        #1;
        o = sample();
        n_cyc++;
        if (o.inc_pc) n_inc++;
        check($sformatf("%s ir=%h", tag, cur_ir), {10'b0, o}, {10'b0, e});
        check("bus_sel_onehot0",
              32'($countones({o.sel_mem, o.sel_pc, o.sel_alu, o.sel_r}) <= 1), 32'd1);
        check("load_r_onehot0", 32'($countones(o.load_r) <= 1), 32'd1);
    endtask

    // Holds reset for one cycle; every output must be 0 whatever ready does.
    task automatic do_reset(input bit rdy);
        @(negedge clk);
        reset        = 1'b1;
        bus_if.ready = rdy;
        #1;
        check("reset_outputs_zero", {10'b0, sample()}, 32'd0);
    endtask

    function automatic bit is_illegal(input logic [3:0] opc);
        return !(opc <= 4'h5 || opc == 4'hF);
    endfunction

    function automatic bit stops_core(input logic [3:0] opc);
`ifdef ILLEGAL_TRAP_EN
        return (opc == 4'hF) || is_illegal(opc);
`else
        return (opc == 4'hF);
`endif
    endfunction

    // Reference model: the expected cycle sequence of one instruction.
    // wf/wl = wait cycles in the fetch and LDI reads; n_hold = cycles to
    // observe a stopped core (the caller then applies reset).
    task automatic run_instr(input logic [7:0] irv, input int wf, input int wl, input int n_hold);
        out_t       e;
        logic [3:0] opc;
        int         src;
        int         dst;
        opc    = irv[7:4];
        src    = irv[3:2];
        dst    = irv[1:0];
        cur_ir = irv;

        e = '0; e.sel_pc = 1; e.load_ar = 1;
        step("fetch1", rnd_bit(), e);
        e = '0; e.mem_rd = 1;
        repeat (wf) step("fetch_wait", 1'b0, e);
        e = '0; e.mem_rd = 1; e.sel_mem = 1; e.load_ir = 1; e.inc_pc = 1;
        step("fetch_data", 1'b1, e);
        e = '0;
        step("decode", rnd_bit(), e);

        if (opc >= 4'h1 && opc <= 4'h3) begin
            e = '0; e.sel_r = 4'(1 << src); e.load_op1 = 1;
            step("alu_ex1", rnd_bit(), e);
            e = '0; e.sel_r = 4'(1 << dst); e.load_op2 = 1;
            step("alu_ex2", rnd_bit(), e);
            e = '0; e.sel_alu = 1; e.alu_op = 2'(opc - 4'h1); e.load_flag = 1;
            e.load_r = 4'(1 << dst);
            step("alu_ex3", rnd_bit(), e);
        end else if (opc == 4'h4) begin
            e = '0; e.sel_r = 4'(1 << src); e.load_r = 4'(1 << dst);
            step("mov_ex1", rnd_bit(), e);
        end else if (opc == 4'h5) begin
            e = '0; e.sel_pc = 1; e.load_ar = 1;
            step("ldi1", rnd_bit(), e);
            e = '0; e.mem_rd = 1;
            repeat (wl) step("ldi_wait", 1'b0, e);
            e = '0; e.mem_rd = 1; e.sel_mem = 1; e.inc_pc = 1; e.load_r = 4'(1 << dst);
            step("ldi_data", 1'b1, e);
        end else if (stops_core(opc)) begin
            e = '0; e.halted = 1; e.error = is_illegal(opc);
            repeat (n_hold) step("stopped", rnd_bit(), e);
        end
        // NOP, and illegal opcodes without the trap option, end at DECODE.
    endtask

    initial begin
        logic [7:0] irv;
        int         pick;
        bus_if.ready = 1'b0;
        bus_if.ir    = 8'h00;

        do_reset(1'b0);
        do_reset(1'b1);

        // ADD R1,R2: six cycles with zero-wait memory.
        n_cyc = 0;
        run_instr(8'h16, 0, 0, 0);
        check("add_cycles", 32'(n_cyc), 32'd6);

        // LDI R3 with two wait cycles on each read.
        n_inc = 0;
        n_cyc = 0;
        run_instr(8'h53, 2, 2, 0);
        check("ldi_inc_pc_pulses", 32'(n_inc), 32'd2);
        check("ldi_cycles", 32'(n_cyc), 32'd9);

        // MOV with src == dest, then NOP.
        run_instr(8'h45, 0, 0, 0);
        run_instr(8'h00, 1, 0, 0);

        // HLT held for 20 cycles, then reset back to FETCH1.
        run_instr(8'hF0, 0, 0, 20);
        do_reset(rnd_bit());

        // Illegal opcode 0x9.
        n_cyc = 0;
        run_instr(8'h90, 0, 0, 5);
`ifdef ILLEGAL_TRAP_EN
        do_reset(1'b1);
`else
        check("illegal_as_nop_cycles", 32'(n_cyc), 32'd3);
`endif

        // Reset during a fetch wait: no load_ir, restart at FETCH1.
        begin
            out_t e;
            cur_ir = 8'h16;
            e = '0; e.sel_pc = 1; e.load_ar = 1;
            step("fetch1_pre_abort", 1'b1, e);
            e = '0; e.mem_rd = 1;
            step("fetch_wait_pre_abort", 1'b0, e);
            step("fetch_wait_pre_abort", 1'b0, e);
            do_reset(1'b0);
            do_reset(1'b1);
        end
        run_instr(8'h2E, 0, 1, 0);

        // Random instruction stream with random memory waits.
        for (int i = 0; i < 500; i++) begin
            pick = $urandom_range(0, 99);
            irv  = 8'($urandom_range(0, 255));
            if (pick < 2)      irv[7:4] = 4'hF;
            else if (pick < 6) irv[7:4] = 4'($urandom_range(6, 14));
            else               irv[7:4] = 4'($urandom_range(0, 5));
            run_instr(irv, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 4));
            if (stops_core(irv[7:4])) do_reset(rnd_bit());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
